binary_bcd_seq: RTL and testbench
=================================

Name: binary_bcd_seq

Overview:
Parametrised, multi-cycle binary-to-BCD converter using shift-and-add-3 (double dabble). It processes one input bit per clock and uses valid/ready handshakes on both input and output. It sits between the multiplier result and the display/encoder path. It adds over the current converter:
- generic input width and digit count
- optional signed input
- overflow detection
- a significant-digit count for leading-zero blanking

Parameters:
IN_WIDTH, 16, binary input width in bits (>=2).
DIGITS, 5, number of BCD output digits; output width is 4*DIGITS.
SIGNED, 0, 1 = in_data is two's complement, converted as magnitude plus sign flag.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept in_data this cycle
in_data  input  IN_WIDTH  binary operand
out_valid  output  1  result fields valid
out_ready  input  1  consumer takes result this cycle
out_bcd  output  4*DIGITS  packed BCD, digit 0 in [3:0]
out_neg  output  1  result negative (always 0 when SIGNED=0)
out_digits  output  $clog2(DIGITS+1)  significant digits, 1..DIGITS (value 0 gives 1)
out_overflow  output  1  value did not fit in DIGITS digits; out_bcd is undefined-but-stable

Behaviour:
- Reset (asynchronous, any state, including mid-conversion):
  - state=IDLE, bit counter=0
  - BCD and shift registers=0, out_neg=0, out_overflow=0, out_valid=0
  - in_ready=1 after reset release
  - Any in-flight conversion is discarded; no output is produced for it.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On in_valid at a clk edge, capture the operand (the magnitude when SIGNED=1), clear the BCD field and overflow flag, set out_neg=(SIGNED && in_data[MSB]), counter=0, go to SHIFT.
  - SHIFT: in_ready=0, out_valid=0. Each edge:
    - add 3 to every BCD nibble >4
    - shift {bcd, operand} left by 1
    - if the bit shifted out of the top BCD nibble is 1, set overflow (sticky)
    - increment the counter
    - on the edge where counter reaches IN_WIDTH-1, go to DONE
  - DONE: out_valid=1, and results are held stable while out_ready=0.
    - in_ready = out_ready (pass-through accept).
    - On out_ready: if in_valid, accept the new operand as in IDLE and go to SHIFT; else go to IDLE.
- Latency: operand accepted at edge E0 -> out_valid high in the cycle after edge E0+IN_WIDTH. Throughput is one result per IN_WIDTH+1 cycles with back-to-back traffic.
- Signed magnitude: computed as (~x)+1 at capture, held in IN_WIDTH bits. -2^(IN_WIDTH-1) converts correctly as unsigned magnitude. Negative zero cannot occur.
- out_digits:
  - combinational from the out_bcd register: index of the highest nonzero nibble +1
  - 1 if all nibbles are zero
  - meaningful only while out_valid=1
- out_bcd, out_neg, out_digits and out_overflow are not updated while out_valid=1 and out_ready=0.
- in_valid in SHIFT is ignored (in_ready=0). No data is dropped, since the producer must hold its data until accepted.

Decomposition:
- Package bcd_pkg holds:
  - the state enum (IDLE, SHIFT, DONE)
  - a BCD nibble typedef
  - a constant function for the minimum digits required for a given width (used in assertions and by instantiators)
- One natural sub-module: bcd_digit_adjust, a combinational add-3-if->4 on a single nibble, instantiated DIGITS times via generate.
- Counter width is $clog2(IN_WIDTH).

Test Plan:
- Defaults, in_data=16'hFFFF, out_ready=1 -> out_valid 16 cycles after accept; out_bcd=20'h65535, out_digits=5, out_overflow=0, out_neg=0.
- in_data=0 -> out_bcd=0, out_digits=1. in_data=16'd907 -> out_bcd=20'h00907, out_digits=3.
- SIGNED=1, in_data=-16'sd1234 -> out_bcd=20'h01234, out_neg=1, out_digits=4. in_data=16'h8000 -> out_bcd=20'h32768, out_neg=1.
- DIGITS=4, in_data=16'd12345 -> out_overflow=1. in_data=16'd9999 -> out_bcd=16'h9999, out_overflow=0.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> outputs and out_valid held, in_ready=0. Release together with in_valid=1 (next=42) -> first result dropped from the bus on that edge, conversion of 42 starts, next result 16'h00042.
- Reset asserted at SHIFT counter=7 -> all outputs return to reset values immediately; in_ready=1 after release; the next conversion (500) yields 20'h00500 with no stale bits.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  typedef logic [3:0] nibble_t;

  // Decimal digits needed for 2**width-1: ceil(width*log10(2)) in fixed point.
  function automatic int min_bcd_digits(input int width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction: add 3 to a BCD nibble whose value exceeds 4.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  nibble_t din,
  output nibble_t dout
);

  assign dout = (din > 4'd4) ? din + 4'd3 : din;

endmodule

// File: rtl/binary_bcd_seq.sv
// Multi-cycle binary-to-BCD converter, one operand bit per clock, with
// valid/ready on both sides, optional signed input and overflow detection.
module binary_bcd_seq
  import bcd_pkg::*;
#(
  parameter int IN_WIDTH = 16,
  parameter int DIGITS   = 5,
  parameter bit SIGNED   = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IN_WIDTH-1:0]          in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [4*DIGITS-1:0]          out_bcd,
  output logic                         out_neg,
  output logic [$clog2(DIGITS+1)-1:0]  out_digits,
  output logic                         out_overflow
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high. The producer holds in_data until in_ready; results stay frozen
  // while out_valid is high and out_ready is low.

  localparam int BW  = 4 * DIGITS;
  localparam int CW  = $clog2(IN_WIDTH);
  localparam int DW  = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] LAST = CW'(IN_WIDTH - 1);
  // When the digit field always fits the widest operand the flag is tied off.
  localparam bit CAN_OVF = DIGITS < min_bcd_digits(IN_WIDTH);

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q;
  logic [BW-1:0]       bcd_q;
  logic [BW-1:0]       adj;
  logic [IN_WIDTH-1:0] opnd_q;
  logic [IN_WIDTH-1:0] mag;
  logic                neg_q, ovf_q;
  logic                accept, shift_en;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .din  (bcd_q[4*g +: 4]),
      .dout (adj[4*g +: 4])
    );
  end

  assign mag = (SIGNED && in_data[IN_WIDTH-1]) ? (~in_data + IN_WIDTH'(1)) : in_data;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    shift_en  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            accept  = 1'b1;
            state_d = SHIFT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bcd_q   <= '0;
      opnd_q  <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        opnd_q <= mag;
        bcd_q  <= '0;
        ovf_q  <= 1'b0;
        neg_q  <= SIGNED && in_data[IN_WIDTH-1];
        cnt_q  <= '0;
      end else if (shift_en) begin
        bcd_q  <= {adj[BW-2:0], opnd_q[IN_WIDTH-1]};
        opnd_q <= {opnd_q[IN_WIDTH-2:0], 1'b0};
        if (CAN_OVF && adj[BW-1]) ovf_q <= 1'b1;
        cnt_q  <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      end
    end
  end

  // Significant digits: position of the highest nonzero nibble, minimum 1.
  always_comb begin
    out_digits = DW'(1);
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) out_digits = DW'(i + 1);
    end
  end

  assign out_bcd      = bcd_q;
  assign out_neg      = neg_q;
  assign out_overflow = ovf_q;

endmodule

// File: tb/tb_binary_bcd_seq.sv
// Bench for binary_bcd_seq: three configurations share one stimulus stream,
// each with its own decimal reference model and expected-result queue.
module tb_binary_bcd_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        out_ready = 1'b1;

  logic        def_in_ready, def_out_valid, def_neg, def_ovf;
  logic [19:0] def_bcd;
  logic [2:0]  def_dig;
  logic        sgn_in_ready, sgn_out_valid, sgn_neg, sgn_ovf;
  logic [19:0] sgn_bcd;
  logic [2:0]  sgn_dig;
  logic        d4_in_ready, d4_out_valid, d4_neg, d4_ovf;
  logic [15:0] d4_bcd;
  logic [2:0]  d4_dig;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int accept_cyc = 0;

  // Packed expectation: {overflow, neg, digits[2:0], bcd[19:0]}
  logic [24:0] q_def[$];
  logic [24:0] q_sgn[$];
  logic [24:0] q_d4[$];

  binary_bcd_seq #(.IN_WIDTH(16), .DIGITS(5), .SIGNED(1'b0)) u_def (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(def_in_ready),
    .in_data(in_data), .out_valid(def_out_valid), .out_ready(out_ready),
    .out_bcd(def_bcd), .out_neg(def_neg), .out_digits(def_dig), .out_overflow(def_ovf)
  );

  binary_bcd_seq #(.IN_WIDTH(16), .DIGITS(5), .SIGNED(1'b1)) u_sgn (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(sgn_in_ready),
    .in_data(in_data), .out_valid(sgn_out_valid), .out_ready(out_ready),
    .out_bcd(sgn_bcd), .out_neg(sgn_neg), .out_digits(sgn_dig), .out_overflow(sgn_ovf)
  );

  binary_bcd_seq #(.IN_WIDTH(16), .DIGITS(4), .SIGNED(1'b0)) u_d4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(d4_in_ready),
    .in_data(in_data), .out_valid(d4_out_valid), .out_ready(out_ready),
    .out_bcd(d4_bcd), .out_neg(d4_neg), .out_digits(d4_dig), .out_overflow(d4_ovf)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [24:0] model(input logic [15:0] x, input int nd, input bit sgn);
    int unsigned v;
    logic [19:0] b;
    logic [2:0]  d;
    logic        n, o;
    n = sgn && x[15];
    v = n ? (32'd65536 - {16'd0, x}) : {16'd0, x};
    b = '0;
    for (int i = 0; i < nd; i++) begin
      b[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    o = (v != 0);
    d = 3'd1;
    for (int i = 0; i < 5; i++) begin
      if (b[4*i +: 4] != 4'd0) d = 3'(i + 1);
    end
    return {o, n, d, b};
  endfunction

  // BCD and digit count are only defined when no overflow is expected.
  task automatic check_result(input string pfx, input logic [24:0] got, input logic [24:0] exp);
    if (!exp[24]) begin
      check({pfx, "_bcd"}, 32'(got[19:0]), 32'(exp[19:0]));
      check({pfx, "_digits"}, 32'(got[22:20]), 32'(exp[22:20]));
    end
    check({pfx, "_neg"}, 32'(got[23]), 32'(exp[23]));
    check({pfx, "_ovf"}, 32'(got[24]), 32'(exp[24]));
  endtask

  // Scoreboard: compare on every output handshake
  always @(negedge clk) begin
    if (!reset && out_ready) begin
      if (def_out_valid) begin
        if (q_def.size() == 0) check("def_unexpected", 32'(def_out_valid), 32'd0);
        else check_result("def", {def_ovf, def_neg, def_dig, def_bcd}, q_def.pop_front());
      end
      if (sgn_out_valid) begin
        if (q_sgn.size() == 0) check("sgn_unexpected", 32'(sgn_out_valid), 32'd0);
        else check_result("sgn", {sgn_ovf, sgn_neg, sgn_dig, sgn_bcd}, q_sgn.pop_front());
      end
      if (d4_out_valid) begin
        if (q_d4.size() == 0) check("d4_unexpected", 32'(d4_out_valid), 32'd0);
        else check_result("d4", {d4_ovf, d4_neg, d4_dig, 4'h0, d4_bcd}, q_d4.pop_front());
      end
    end
  end

  // Driver: called just after a rising edge; returns just after the accept edge.
  task automatic send(input logic [15:0] v);
    int n;
    in_valid = 1'b1;
    in_data  = v;
    n = 0;
    @(negedge clk);
    while (!def_in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 32'(def_in_ready), 32'd1);
    q_def.push_back(model(v, 5, 1'b0));
    q_sgn.push_back(model(v, 5, 1'b1));
    q_d4.push_back(model(v, 4, 1'b0));
    @(posedge clk);
    #2;
    accept_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!def_out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(def_out_valid), 32'd1);
  endtask

  logic [15:0] vec [6] = '{16'd0, 16'd907, 16'hFB2E, 16'h8000, 16'd12345, 16'd9999};
  logic [24:0] m777;

  initial begin
    // Reset state
    #1 reset = 1'b1;
    #1;
    check("rst_out_valid", 32'(def_out_valid), 32'd0);
    check("rst_bcd", 32'(def_bcd), 32'd0);
    check("rst_neg", 32'(sgn_neg), 32'd0);
    check("rst_ovf", 32'(d4_ovf), 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    #1 check("rst_in_ready", 32'(def_in_ready), 32'd1);
    @(posedge clk);
    #2;

    // Latency of the first conversion
    send(16'hFFFF);
    wait_valid("lat_valid");
    check("latency", 32'(cyc - accept_cyc), 32'd16);
    @(posedge clk);
    #2;

    // Back-to-back traffic through the pass-through accept
    foreach (vec[i]) send(vec[i]);
    for (int i = 0; i < 4; i++) send(16'($urandom_range(0, 65535)));
    wait_valid("last_valid");
    @(posedge clk);
    #2;

    // Backpressure: results held, no new operand accepted
    out_ready = 1'b0;
    m777 = model(16'd777, 5, 1'b0);
    send(16'd777);
    wait_valid("bp_valid");
    for (int i = 0; i < 10; i++) begin
      check("bp_hold_valid", 32'(def_out_valid), 32'd1);
      check("bp_hold_ready", 32'(def_in_ready), 32'd0);
      check("bp_hold_bcd", 32'(def_bcd), 32'(m777[19:0]));
      @(negedge clk);
    end
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    send(16'd42);
    @(negedge clk);
    check("bp_dropped", 32'(def_out_valid), 32'd0);
    wait_valid("bp_next_valid");
    @(posedge clk);
    #2;

    // Reset in the middle of a conversion (counter = 7)
    send(16'hFC18);
    repeat (7) @(posedge clk);
    #2;
    reset = 1'b1;
    q_def.delete();
    q_sgn.delete();
    q_d4.delete();
    #1;
    check("mid_rst_valid", 32'(def_out_valid), 32'd0);
    check("mid_rst_bcd", 32'(def_bcd), 32'd0);
    check("mid_rst_sgn_bcd", 32'(sgn_bcd), 32'd0);
    check("mid_rst_neg", 32'(sgn_neg), 32'd0);
    check("mid_rst_ovf", 32'(def_ovf), 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check("mid_rst_in_ready", 32'(def_in_ready), 32'd1);
    @(posedge clk);
    #2;
    send(16'd500);

    // Drain the scoreboard
    for (int n = 0; n < 100; n++) begin
      if (q_def.size() == 0 && q_sgn.size() == 0 && q_d4.size() == 0) break;
      @(negedge clk);
    end
    check("drain", 32'(q_def.size() + q_sgn.size() + q_d4.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
